// File: rtl/dac_segmented_dem_encoder_pkg.sv
// Shared definitions for the segmented-DAC DEM encoder: DEM mode encodings,
// LFSR geometry and the LFSR next-state function.
package dac_interface_pkg;

  typedef enum logic [1:0] {
    DEM_STATIC = 2'b00,
    DEM_RANDOM = 2'b01,
    DEM_DWA    = 2'b10,
    DEM_RSVD   = 2'b11
  } dem_mode_e;

  localparam int          LFSR_W            = 16;
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Fibonacci step: shift left, XOR of tapped bits 15/13/12/10 enters bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dac_segmented_dem_encoder_if.sv
// Sample-in / unit-cell-out bundle of the segmented-DAC DEM encoder.
interface dac_segmented_dem_encoder_if #(
  parameter int INPUT_WIDTH = 10,
  parameter int THERM_BITS  = 6
);
  localparam int L     = 2**THERM_BITS;
  localparam int BIN_W = INPUT_WIDTH - THERM_BITS;

  logic [1:0]             mode_i;
  logic                   valid_i;
  logic [INPUT_WIDTH-1:0] sample_i;
  logic [L-1:0]           therm_o;
  logic [BIN_W-1:0]       bin_o;
  logic                   valid_o;

  modport master (
    output mode_i, valid_i, sample_i,
    input  therm_o, bin_o, valid_o
  );

  modport slave (
    input  mode_i, valid_i, sample_i,
    output therm_o, bin_o, valid_o
  );

endinterface

// File: rtl/dac_segmented_dem_encoder_lfsr.sv
// dac_lfsr: 16-bit Fibonacci LFSR that steps once per advance_i pulse and
// exposes its low OUT_W bits as the random rotation amount.
module dac_lfsr
  import dac_interface_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = LFSR_DEFAULT_SEED,
  parameter int                OUT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             advance_i,
  output logic [OUT_W-1:0] state_o
);

  if (OUT_W < 1 || OUT_W > LFSR_W) begin : g_bad_out_w
    $error("dac_lfsr: OUT_W must be within 1..16");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("dac_lfsr: SEED must be nonzero");
  end

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SEED;
    end else if (advance_i) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign state_o = r_state[OUT_W-1:0];

endmodule

// File: rtl/dac_segmented_dem_encoder.sv
// Segmented-DAC front end: thermometer MSBs with static/random/DWA rotation,
// pass-through LSBs, 2-cycle latency. Optional status ports: DAC_DEM_STATUS_EN.
module dac_segmented_dem_encoder
  import dac_interface_pkg::*;
#(
  parameter int                INPUT_WIDTH = 10,
  parameter int                THERM_BITS  = 6,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
`ifdef DAC_DEM_STATUS_EN
  output logic [15:0]           wrap_cnt_o,
  output logic [THERM_BITS-1:0] pointer_o,
`endif
  dac_segmented_dem_encoder_if.slave bus
);

  localparam int L     = 2**THERM_BITS;
  localparam int BIN_W = INPUT_WIDTH - THERM_BITS;

  if (THERM_BITS < 1 || THERM_BITS >= INPUT_WIDTH) begin : g_bad_therm_bits
    $error("dac_segmented_dem_encoder: need 1 <= THERM_BITS < INPUT_WIDTH");
  end
  if (THERM_BITS > LFSR_W) begin : g_therm_too_wide
    $error("dac_segmented_dem_encoder: THERM_BITS > 16 is not supported");
  end

  logic [THERM_BITS-1:0] r_t_p1;
  logic [BIN_W-1:0]      r_b_p1;
  dem_mode_e             r_mode_p1;
  logic                  r_vld_p1;

  logic [L-1:0]          r_therm_p2;
  logic [BIN_W-1:0]      r_bin_p2;
  logic                  r_vld_p2;
  logic [THERM_BITS-1:0] r_ptr;

  logic [L-1:0]          w_u;
  logic [THERM_BITS-1:0] w_rot;
  logic [2*L-1:0]        w_dbl;
  logic [THERM_BITS-1:0] w_ptr_next;
  logic [THERM_BITS-1:0] w_lfsr_bits;

  // Stage 1: split the sample and latch the mode it was sent with
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_t_p1    <= '0;
      r_b_p1    <= '0;
      r_mode_p1 <= DEM_STATIC;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= bus.valid_i;
      if (bus.valid_i) begin
        r_t_p1    <= bus.sample_i[INPUT_WIDTH-1 -: THERM_BITS];
        r_b_p1    <= bus.sample_i[BIN_W-1:0];
        r_mode_p1 <= dem_mode_e'(bus.mode_i);
      end
    end
  end

  dac_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (THERM_BITS)
  ) u_lfsr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance_i (r_vld_p1),
    .state_o   (w_lfsr_bits)
  );

  always_comb begin
    w_u = '0;
    for (int j = 0; j < L; j++) begin
      w_u[j] = (THERM_BITS'(j) < r_t_p1);
    end
  end

  always_comb begin
    w_rot = '0;
    case (r_mode_p1)
      DEM_RANDOM: w_rot = w_lfsr_bits;
      DEM_DWA:    w_rot = r_ptr;
      default:    w_rot = '0;
    endcase
  end

  // Upper half of the doubled word is u rotated left by w_rot.
  assign w_dbl      = {w_u, w_u} << w_rot;
  assign w_ptr_next = r_ptr + r_t_p1;

  // Stage 2: rotate onto unit cells and advance the DWA pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_therm_p2 <= '0;
      r_bin_p2   <= '0;
      r_vld_p2   <= 1'b0;
      r_ptr      <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_therm_p2 <= w_dbl[2*L-1:L];
        r_bin_p2   <= r_b_p1;
        r_ptr      <= (r_mode_p1 == DEM_DWA) ? w_ptr_next : '0;
      end
    end
  end

  assign bus.therm_o = r_therm_p2;
  assign bus.bin_o   = r_bin_p2;
  assign bus.valid_o = r_vld_p2;

`ifdef DAC_DEM_STATUS_EN
  logic [15:0] r_wrap_cnt;
  logic        w_wrap;

  // Natural wrap of the pointer add shows up as the sum dropping below r_ptr.
  assign w_wrap = r_vld_p1 && (r_mode_p1 == DEM_DWA) && (w_ptr_next < r_ptr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrap_cnt <= '0;
    end else if (w_wrap && (r_wrap_cnt != 16'hFFFF)) begin
      r_wrap_cnt <= r_wrap_cnt + 16'd1;
    end
  end

  assign wrap_cnt_o = r_wrap_cnt;
  assign pointer_o  = r_ptr;
`endif

endmodule
